// File: rtl/despertador_pkg.sv
// Shared definitions for the alarm-clock input front end.
// Contents: per-button FSM state enum, default cycle constants (50 MHz board),
// and a helper that sizes down-counters from a cycle span.
package despertador_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  localparam int unsigned DEB_CYCLES_DEF        = 1_000_000;
  localparam int unsigned RPT_DELAY_CYCLES_DEF  = 25_000_000;
  localparam int unsigned RPT_PERIOD_CYCLES_DEF = 5_000_000;

  // Bits needed for a counter that runs 0 .. span-1 (at least one bit).
  function automatic int unsigned cnt_width(int unsigned span);
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/despertador_entradas_if.sv
// Board-side signal bundle of the alarm-clock input front end.
// Signals: five raw board inputs (three active-low buttons, two switches)
// and the five conditioned outputs towards the CPU PIO.
// Modports: master = board/stimulus side (drives raw, reads exports),
//           slave  = conditioning logic side (reads raw, drives exports).
interface despertador_entradas_if;
  logic btnapagar_raw;
  logic btnhora_raw;
  logic btnmin_raw;
  logic swinicio_raw;
  logic swmodo_raw;
  logic btnapagar_export;
  logic btnhora_export;
  logic btnmin_export;
  logic swinicio_export;
  logic swmodo_export;

  modport master (
    output btnapagar_raw, btnhora_raw, btnmin_raw, swinicio_raw, swmodo_raw,
    input  btnapagar_export, btnhora_export, btnmin_export,
           swinicio_export, swmodo_export
  );

  modport slave (
    input  btnapagar_raw, btnhora_raw, btnmin_raw, swinicio_raw, swmodo_raw,
    output btnapagar_export, btnhora_export, btnmin_export,
           swinicio_export, swmodo_export
  );
endinterface

// File: rtl/despertador.sv
// Input front end of the alarm clock lives in despertador_entradas.sv.

// File: rtl/despertador_antirebote.sv
// Two-flop synchronizer followed by a level debouncer for one raw input.
// Ports: clk, rst (async, active-high), din (raw asynchronous input),
//        level (debounced level, 0 after reset).
// Parameters: DEB_CYCLES (consecutive stable cycles to accept a change),
//             INVERT (1 for active-low inputs so that level=1 means active).
module despertador_antirebote
  import despertador_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter bit          INVERT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level
);

  localparam int unsigned     CW   = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(DEB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Polarity is folded into the first flop so a reset synchronizer (all 0)
  // always reads as "inactive", whatever the board polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= din ^ INVERT;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/despertador_entradas.sv
// Input conditioning for the alarm clock: synchronizes and debounces three
// active-low pushbuttons and two slide switches, turns button presses into
// one-cycle event pulses for the CPU PIO and exports debounced switch levels.
// Ports: clk_clk, reset_reset (async, active-high); *_raw board inputs;
//        btn*_export event pulses; sw*_export debounced levels.
// Build option: define DESPERTADOR_AUTOREPEAT_EN to enable hold-to-repeat
// on btnhora/btnmin; without it every button gives one pulse per press.
module despertador_entradas
  import despertador_pkg::*;
#(
  parameter int unsigned DEB_CYCLES        = DEB_CYCLES_DEF,
  parameter int unsigned RPT_DELAY_CYCLES  = RPT_DELAY_CYCLES_DEF,
  parameter int unsigned RPT_PERIOD_CYCLES = RPT_PERIOD_CYCLES_DEF
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic btnapagar_raw,
  input  logic btnhora_raw,
  input  logic btnmin_raw,
  input  logic swinicio_raw,
  input  logic swmodo_raw,
  output logic btnapagar_export,
  output logic btnhora_export,
  output logic btnmin_export,
  output logic swinicio_export,
  output logic swmodo_export
);

  localparam int unsigned NBTN = 3;  // index 0 = apagar, 1 = hora, 2 = min

  if (DEB_CYCLES < 1 || RPT_DELAY_CYCLES < 1 || RPT_PERIOD_CYCLES < 1) begin : g_param_check
    $error("despertador_entradas: cycle parameters must be at least 1");
  end

  logic [NBTN-1:0] pressed;
  logic [NBTN-1:0] fire;
  logic [NBTN-1:0] pulse;
  logic [NBTN-1:0] pulse_nx;
  btn_state_t      state    [NBTN];
  btn_state_t      state_nx [NBTN];

  despertador_antirebote #(.DEB_CYCLES(DEB_CYCLES), .INVERT(1'b1)) u_apagar (
    .clk(clk_clk), .rst(reset_reset), .din(btnapagar_raw), .level(pressed[0])
  );
  despertador_antirebote #(.DEB_CYCLES(DEB_CYCLES), .INVERT(1'b1)) u_hora (
    .clk(clk_clk), .rst(reset_reset), .din(btnhora_raw), .level(pressed[1])
  );
  despertador_antirebote #(.DEB_CYCLES(DEB_CYCLES), .INVERT(1'b1)) u_min (
    .clk(clk_clk), .rst(reset_reset), .din(btnmin_raw), .level(pressed[2])
  );
  despertador_antirebote #(.DEB_CYCLES(DEB_CYCLES), .INVERT(1'b0)) u_inicio (
    .clk(clk_clk), .rst(reset_reset), .din(swinicio_raw), .level(swinicio_export)
  );
  despertador_antirebote #(.DEB_CYCLES(DEB_CYCLES), .INVERT(1'b0)) u_modo (
    .clk(clk_clk), .rst(reset_reset), .din(swmodo_raw), .level(swmodo_export)
  );

`ifdef DESPERTADOR_AUTOREPEAT_EN
  localparam int unsigned   SPAN =
    (RPT_DELAY_CYCLES > RPT_PERIOD_CYCLES) ? RPT_DELAY_CYCLES : RPT_PERIOD_CYCLES;
  localparam int unsigned   RW          = cnt_width(SPAN);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(RPT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(RPT_PERIOD_CYCLES - 1);

  logic [RW-1:0] cnt    [NBTN];
  logic [RW-1:0] cnt_nx [NBTN];
`endif

  always_comb begin
    for (int unsigned i = 0; i < NBTN; i++) begin
      state_nx[i] = state[i];
      fire[i]     = 1'b0;
`ifdef DESPERTADOR_AUTOREPEAT_EN
      cnt_nx[i]   = cnt[i];
`endif
      case (state[i])
        IDLE: begin
          if (pressed[i]) begin
            state_nx[i] = HELD;
            fire[i]     = 1'b1;
`ifdef DESPERTADOR_AUTOREPEAT_EN
            cnt_nx[i]   = '0;
`endif
          end
        end
        HELD: begin
          // Release is checked first so it beats a coincident deadline.
          if (!pressed[i]) begin
            state_nx[i] = IDLE;
          end
`ifdef DESPERTADOR_AUTOREPEAT_EN
          else if (i != 0) begin
            if (cnt[i] == DELAY_LAST) begin
              state_nx[i] = REPEAT;
              fire[i]     = 1'b1;
              cnt_nx[i]   = '0;
            end else if (cnt[i] != '1) begin
              cnt_nx[i] = cnt[i] + RW'(1);
            end
          end
`endif
        end
`ifdef DESPERTADOR_AUTOREPEAT_EN
        REPEAT: begin
          if (!pressed[i]) begin
            state_nx[i] = IDLE;
          end else if (cnt[i] == PERIOD_LAST) begin
            fire[i]   = 1'b1;
            cnt_nx[i] = '0;
          end else if (cnt[i] != '1) begin
            cnt_nx[i] = cnt[i] + RW'(1);
          end
        end
`endif
        default: state_nx[i] = IDLE;
      endcase
    end

    // Suppression only masks the pulse; the FSMs keep their own timing so
    // repeats resume on schedule without replaying what was masked.
    pulse_nx[0] = fire[0];
    pulse_nx[1] = fire[1] & ~pressed[0];
    pulse_nx[2] = fire[2] & ~pressed[0];
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pulse <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        state[i] <= IDLE;
`ifdef DESPERTADOR_AUTOREPEAT_EN
        cnt[i]   <= '0;
`endif
      end
    end else begin
      pulse <= pulse_nx;
      for (int unsigned i = 0; i < NBTN; i++) begin
        state[i] <= state_nx[i];
`ifdef DESPERTADOR_AUTOREPEAT_EN
        cnt[i]   <= cnt_nx[i];
`endif
      end
    end
  end

  assign btnapagar_export = pulse[0];
  assign btnhora_export   = pulse[1];
  assign btnmin_export    = pulse[2];

endmodule

// File: tb/tb_despertador_entradas.sv
// Bench for despertador_entradas with short timing (DEB=4, DELAY=20, PERIOD=8).
// A behavioural model predicts every output on every cycle; directed
// scenarios additionally check pulse timing against fixed offsets.
module tb_despertador_entradas;

  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 8;
`ifdef DESPERTADOR_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  despertador_entradas_if bus ();

  despertador_entradas #(
    .DEB_CYCLES(DEB),
    .RPT_DELAY_CYCLES(DLY),
    .RPT_PERIOD_CYCLES(PER)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .btnapagar_raw(bus.btnapagar_raw),
    .btnhora_raw(bus.btnhora_raw),
    .btnmin_raw(bus.btnmin_raw),
    .swinicio_raw(bus.swinicio_raw),
    .swmodo_raw(bus.swmodo_raw),
    .btnapagar_export(bus.btnapagar_export),
    .btnhora_export(bus.btnhora_export),
    .btnmin_export(bus.btnmin_export),
    .swinicio_export(bus.swinicio_export),
    .swmodo_export(bus.swmodo_export)
  );

  int n_checks = 0;
  int n_errors = 0;
  int tick_no  = 0;

  // Model state: index 0 apagar, 1 hora, 2 min, 3 inicio, 4 modo.
  int n_edge;
  bit lvl      [5];
  bit pipe_q   [5][$];
  bit win      [5][$];
  int press_at [5];
  bit exp_out  [5];

  // Observed pulse times (0..2) and swmodo rising edges (3).
  int log_q [4][$];
  logic modo_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d (tick %0d)", tag, obs, expv, tick_no);
    end
  endtask

  function automatic bit cur_in(input int i);
    case (i)
      0:       return ~bus.btnapagar_raw;
      1:       return ~bus.btnhora_raw;
      2:       return ~bus.btnmin_raw;
      3:       return bus.swinicio_raw;
      default: return bus.swmodo_raw;
    endcase
  endfunction

  task automatic model_reset();
    n_edge = 0;
    for (int i = 0; i < 5; i++) begin
      lvl[i]      = 1'b0;
      press_at[i] = -1;
      exp_out[i]  = 1'b0;
      pipe_q[i]   = {1'b0, 1'b0};
      win[i].delete();
      for (int k = 0; k < DEB; k++) win[i].push_back(1'b0);
    end
  endtask

  // One clock edge of the behavioural model. Pulse rules use the accepted
  // levels from before this edge; then new samples enter the debounce windows.
  task automatic model_edge();
    bit prev [5];
    bit s;
    bit all_diff;
    int e;
    n_edge++;
    for (int i = 0; i < 5; i++) prev[i] = lvl[i];
    for (int i = 0; i < 3; i++) begin
      exp_out[i] = 1'b0;
      if (prev[i]) begin
        e = n_edge - (press_at[i] + 1);
        if (e == 0) exp_out[i] = 1'b1;
        else if (AUTOREP && i != 0 && e >= DLY && ((e - DLY) % PER) == 0) exp_out[i] = 1'b1;
        if (i != 0 && prev[0]) exp_out[i] = 1'b0;
      end
    end
    for (int i = 0; i < 5; i++) begin
      s = pipe_q[i].pop_front();
      pipe_q[i].push_back(cur_in(i));
      win[i].push_back(s);
      void'(win[i].pop_front());
      all_diff = 1'b1;
      for (int k = 0; k < win[i].size(); k++) if (win[i][k] == lvl[i]) all_diff = 1'b0;
      if (all_diff) begin
        lvl[i] = ~lvl[i];
        if (lvl[i]) press_at[i] = n_edge;
      end
    end
    exp_out[3] = lvl[3];
    exp_out[4] = lvl[4];
  endtask

  task automatic tick();
    @(posedge clk);
    tick_no++;
    if (rst) begin
      for (int i = 0; i < 5; i++) exp_out[i] = 1'b0;
    end else begin
      model_edge();
    end
    #1;
    chk("apagar", bus.btnapagar_export, exp_out[0]);
    chk("hora",   bus.btnhora_export,   exp_out[1]);
    chk("min",    bus.btnmin_export,    exp_out[2]);
    chk("inicio", bus.swinicio_export,  exp_out[3]);
    chk("modo",   bus.swmodo_export,    exp_out[4]);
    if (bus.btnapagar_export === 1'b1) log_q[0].push_back(tick_no);
    if (bus.btnhora_export === 1'b1)   log_q[1].push_back(tick_no);
    if (bus.btnmin_export === 1'b1)    log_q[2].push_back(tick_no);
    if (bus.swmodo_export === 1'b1 && modo_prev !== 1'b1) log_q[3].push_back(tick_no);
    modo_prev = bus.swmodo_export;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_apagar"}, bus.btnapagar_export, 0);
    chk({tag, "_hora"},   bus.btnhora_export,   0);
    chk({tag, "_min"},    bus.btnmin_export,    0);
    chk({tag, "_inicio"}, bus.swinicio_export,  0);
    chk({tag, "_modo"},   bus.swmodo_export,    0);
  endtask

  task automatic chk_log(input string tag, input int which, input int mark, input int exp_off[$]);
    chk({tag, "_count"}, log_q[which].size(), exp_off.size());
    for (int k = 0; k < exp_off.size() && k < log_q[which].size(); k++)
      chk({tag, "_offset"}, log_q[which][k] - mark, exp_off[k]);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 4; i++) log_q[i].delete();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk_zero(tag);
    run(3);
    rst = 1'b0;
  endtask

  initial begin
    int mark;
    int mark2;
    int e_list[$];
    int hold_left [5];
    bit val;

    bus.btnapagar_raw = 1'b1;
    bus.btnhora_raw   = 1'b1;
    bus.btnmin_raw    = 1'b1;
    bus.swinicio_raw  = 1'b0;
    bus.swmodo_raw    = 1'b0;
    #1 rst = 1'b1;
    #1 chk_zero("reset_state");
    model_reset();
    run(3);
    rst = 1'b0;
    run(10);

    // Clean press held 10 cycles: single pulse at +7, nothing on release.
    clear_logs();
    bus.btnhora_raw = 1'b0;
    mark = tick_no;
    run(10);
    bus.btnhora_raw = 1'b1;
    run(20);
    e_list = '{7};
    chk_log("clean_press", 1, mark, e_list);

    // Bouncing press: 2-cycle toggles for 12 cycles, then stable low.
    clear_logs();
    for (int c = 0; c < 12; c++) begin
      bus.btnmin_raw = ((c / 2) % 2 == 1) ? 1'b1 : 1'b0;
      tick();
    end
    bus.btnmin_raw = 1'b0;
    mark = tick_no;
    run(20);
    bus.btnmin_raw = 1'b1;
    run(20);
    e_list = '{7};
    chk_log("bounce_press", 2, mark, e_list);

    // Long hold: repeat schedule (or a single pulse without auto-repeat).
    clear_logs();
    bus.btnhora_raw = 1'b0;
    mark = tick_no;
    run(60);
    bus.btnhora_raw = 1'b1;
    run(20);
`ifdef DESPERTADOR_AUTOREPEAT_EN
    e_list = '{7, 27, 35, 43, 51, 59};
`else
    e_list = '{7};
`endif
    chk_log("long_hold", 1, mark, e_list);

    // apagar held suppresses hora; after apagar release repeats resume.
    clear_logs();
    bus.btnapagar_raw = 1'b0;
    mark = tick_no;
    run(10);
    bus.btnhora_raw = 1'b0;
    mark2 = tick_no;
    run(40);
    bus.btnapagar_raw = 1'b1;
    run(20);
    bus.btnhora_raw = 1'b1;
    run(20);
    e_list = '{7};
    chk_log("apagar_single", 0, mark, e_list);
`ifdef DESPERTADOR_AUTOREPEAT_EN
    e_list = '{51, 59};
`else
    e_list.delete();
`endif
    chk_log("hora_suppressed", 1, mark2, e_list);

    // Reset in the middle of a held min sequence, button still held after.
    clear_logs();
    bus.btnmin_raw = 1'b0;
    run(43);
    reset_pulse("mid_reset");
    clear_logs();
    mark = tick_no;
    run(12);
    e_list = '{7};
    chk_log("held_through_reset", 2, mark, e_list);
    bus.btnmin_raw = 1'b1;
    run(20);

    // swmodo rises with a 2-cycle glitch back to 0 before settling.
    clear_logs();
    bus.swmodo_raw = 1'b1;
    run(2);
    bus.swmodo_raw = 1'b0;
    run(2);
    bus.swmodo_raw = 1'b1;
    mark = tick_no;
    run(12);
    e_list = '{6};
    chk_log("modo_glitch", 3, mark, e_list);
    bus.swinicio_raw = 1'b1;
    run(10);
    bus.swinicio_raw = 1'b0;
    bus.swmodo_raw   = 1'b0;
    run(10);

    // Randomised phase: mixed bounces and long holds, with periodic resets.
    for (int i = 0; i < 5; i++) hold_left[i] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 5; i++) begin
        if (hold_left[i] == 0) begin
          val = 1'($urandom_range(0, 1));
          hold_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(4, 60));
          case (i)
            0:       bus.btnapagar_raw = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            1:       bus.btnhora_raw   = val;
            2:       bus.btnmin_raw    = val;
            3:       bus.swinicio_raw  = val;
            default: bus.swmodo_raw    = val;
          endcase
        end
        hold_left[i]--;
      end
      tick();
      if (t % 700 == 350) reset_pulse("rand_reset");
    end

    bus.btnapagar_raw = 1'b1;
    bus.btnhora_raw   = 1'b1;
    bus.btnmin_raw    = 1'b1;
    run(15);
    reset_pulse("final_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/despertador_entradas.md
DESPERTADOR_ENTRADAS -- requirements
Module: despertador_entradas

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1_000_000, stable-input cycles needed to accept a level change (20 ms at 50 MHz).
REQ-002 SHALL have parameter RPT_DELAY_CYCLES, default 25_000_000, hold time before the first auto-repeat pulse.
REQ-003 SHALL have parameter RPT_PERIOD_CYCLES, default 5_000_000, interval between auto-repeat pulses.
REQ-004 SHALL have ports, clock and reset first:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- btnapagar_raw, btnhora_raw, btnmin_raw  in  1 each  board pushbuttons, active-low, asynchronous.
- swinicio_raw, swmodo_raw  in  1 each  slide switches, asynchronous.
- btnapagar_export, btnhora_export, btnmin_export  out  1 each  one-cycle active-high event pulses to CPU PIO.
- swinicio_export, swmodo_export  out  1 each  debounced switch levels to CPU PIO.

Function
REQ-005 SHALL pass every raw input through a 2-flop synchronizer before any other logic.
REQ-006 SHALL accept a new level only after the synchronized input holds it for DEB_CYCLES consecutive cycles; any toggle SHALL reload the counter.
REQ-007 SHALL run a per-button FSM: IDLE -> HELD on accepted press; HELD -> REPEAT after RPT_DELAY_CYCLES; REPEAT loops every RPT_PERIOD_CYCLES; any state -> IDLE on accepted release.
REQ-008 SHALL emit exactly one pulse the cycle after the IDLE->HELD transition, i.e. DEB_CYCLES+3 cycles after a clean raw edge.
REQ-009 SHALL emit one pulse on HELD->REPEAT and one each RPT_PERIOD_CYCLES in REPEAT, for btnhora and btnmin only.
REQ-010 SHALL never auto-repeat btnapagar; it gives one pulse per press.
REQ-011 SHALL suppress btnhora/btnmin pulses while btnapagar is debounced-pressed; any suppressed button stays in its FSM state and does not replay missed pulses.
REQ-012 SHALL allow btnhora and btnmin to pulse in the same cycle.
REQ-013 SHALL produce no pulse on release, and a release accepted in the same cycle as a repeat deadline SHALL win (no pulse).
REQ-014 SHALL saturate repeat/delay counters; no counter may wrap while a button is held indefinitely.
REQ-015 SHALL drive swinicio_export/swmodo_export as the debounced levels, no pulse generation.

Reset
REQ-016 SHALL on reset_reset assertion immediately clear all pulse outputs, switch outputs, counters and synchronizers to 0 and all FSMs to IDLE.
REQ-017 SHALL treat a button held through reset deassertion as a new press, pulsing after DEB_CYCLES.
REQ-018 SHALL abort any in-progress debounce or repeat sequence when reset asserts mid-operation.

Configuration
REQ-019 SHALL honour macro DESPERTADOR_AUTOREPEAT_EN: defined -> REQ-009 behaviour; undefined -> HELD and REPEAT collapse to one HELD state, with one pulse per press for all buttons and repeat counters removed.

Structure
REQ-020 SHALL place the FSM state enum (IDLE, HELD, REPEAT) and default cycle constants in shared package despertador_pkg.
REQ-021 SHALL implement synchronizer+debouncer as sub-module despertador_antirebote, instantiated once per raw input (5 instances).

Verification (DEB_CYCLES=4, RPT_DELAY_CYCLES=20, RPT_PERIOD_CYCLES=8)
REQ-022 Clean btnhora_raw 1->0 held 10 cycles -> single btnhora_export pulse 7 cycles after edge; none on release.
REQ-023 btnmin_raw bouncing (toggle every 2 cycles for 12 cycles), then stable low -> exactly one pulse, 7 cycles after final edge.
REQ-024 btnhora_raw held 60 cycles with DESPERTADOR_AUTOREPEAT_EN -> pulses at +7, +27, +35, +43, +51, +59; without macro -> only +7.
REQ-025 btnapagar_raw held low, then btnhora_raw pressed and held 60 cycles -> one btnapagar pulse and zero btnhora pulses; release btnapagar -> btnhora repeats resume at next deadline.
REQ-026 reset_reset pulsed mid-REPEAT with btnmin held -> outputs 0 immediately; after deassertion, new pulse 7 cycles later.
REQ-027 swmodo_raw 0->1 with a 2-cycle glitch back to 0 -> swmodo_export rises only after 4 stable cycles, never glitches.
